// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access controller.
// One-hot state encoding matches the generic slave it sits behind.
package i2c_pkg;

    localparam int BYTE_W          = 8;
    localparam int BUS_TIMEOUT_DEF = 255;
    localparam int NUM_STATES      = 6;

    localparam int IDLE_B   = 0;
    localparam int PTR_B    = 1;
    localparam int WDATA_B  = 2;
    localparam int WBUS_B   = 3;
    localparam int RFETCH_B = 4;
    localparam int RHOLD_B  = 5;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE   = 6'b000001,
        ST_PTR    = 6'b000010,
        ST_WDATA  = 6'b000100,
        ST_WBUS   = 6'b001000,
        ST_RFETCH = 6'b010000,
        ST_RHOLD  = 6'b100000
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_STOP,
        EV_START
    } event_e;

    // A start in the same cycle as a stop takes precedence.
    function automatic event_e busEvent(
        input logic start,
        input logic stop
    );
        if (start) return EV_START;
        if (stop)  return EV_STOP;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Simple req/ack register bus between the controller and the register file.
// The controller is the master; the register file answers with ack/rdata.
interface i2c_reg_ctrl_if #(
    parameter int ADDR_W = 8
);
    import i2c_pkg::*;

    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [BYTE_W-1:0] reg_wdata;
    logic [BYTE_W-1:0] reg_rdata;
    logic              reg_ack;

    modport master (
        output reg_req,
        output reg_we,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata,
        input  reg_ack
    );

    modport slave (
        input  reg_req,
        input  reg_we,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata,
        output reg_ack
    );

endinterface

// File: rtl/i2c_bus_timer.sv
// Watchdog for an outstanding register-bus request.
// Reloaded when a request starts or is acknowledged; expires after TIMEOUT cycles.
module i2c_bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic load,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (load || clr) begin
            cnt <= RELOAD;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // An ack in the final cycle beats the timeout.
    assign expire = run && !clr && (cnt == '0);

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-access controller behind the generic I2C slave: pointer byte,
// auto-incrementing writes, prefetched reads and sticky error reporting.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              xfer_start,
    input  logic              xfer_rw,
    input  logic              xfer_stop,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_req,
    input  logic              tx_nack,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    i2c_reg_ctrl_if.master    regBus,
    input  logic              err_clr,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_tmo
);

    state_e            state;
    state_e            stateNxt;
    logic [ADDR_W-1:0] ptrNxt;
    logic [BYTE_W-1:0] txBuf;
    logic [BYTE_W-1:0] txBufNxt;
    logic [BYTE_W-1:0] wdata;
    logic [BYTE_W-1:0] wdataNxt;
    logic              reqQ;
    logic              reqNxt;
    event_e            pendQ;
    event_e            pendNxt;
    logic              pendRwQ;
    logic              pendRwNxt;

    logic   ackIn;
    logic   expire;
    logic   done;
    logic   loadReq;
    logic   readSt;
    event_e evNow;
    event_e effEv;
    logic   effRw;
    logic   doDisp;
    logic   dispRw;
    logic   ovfSet;
    logic   unfSet;
    logic   tmoSet;

    assign ackIn  = regBus.reg_ack & reqQ;
    assign done   = reqQ & (ackIn | expire);
    assign readSt = state[RFETCH_B] | state[RHOLD_B];
    assign evNow  = busEvent(xfer_start,
                             xfer_stop | (tx_nack & readSt));
    // A fresh event in the completion cycle supersedes the parked one.
    assign effEv  = (evNow != EV_NONE) ? evNow : pendQ;
    assign effRw  = (evNow == EV_START) ? xfer_rw : pendRwQ;

    i2c_bus_timer #(
        .TIMEOUT (BUS_TIMEOUT)
    ) uTimer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (loadReq),
        .clr     (ackIn),
        .run     (reqQ),
        .expire  (expire)
    );

    always_comb begin
        stateNxt  = state;
        ptrNxt    = ptr;
        txBufNxt  = txBuf;
        wdataNxt  = wdata;
        reqNxt    = reqQ;
        pendNxt   = pendQ;
        pendRwNxt = pendRwQ;
        loadReq   = 1'b0;
        doDisp    = 1'b0;
        dispRw    = 1'b0;
        ovfSet    = 1'b0;
        unfSet    = 1'b0;
        tmoSet    = 1'b0;

        unique case (1'b1)
            state[IDLE_B]: begin
                if (evNow == EV_START) begin
                    doDisp = 1'b1;
                    dispRw = xfer_rw;
                end
            end
            state[PTR_B]: begin
                if (evNow == EV_START) begin
                    doDisp = 1'b1;
                    dispRw = xfer_rw;
                end else if (evNow == EV_STOP) begin
                    stateNxt = ST_IDLE;
                end else if (rx_valid) begin
                    ptrNxt   = rx_data[ADDR_W-1:0];
                    stateNxt = ST_WDATA;
                end
            end
            state[WDATA_B]: begin
                if (evNow == EV_START) begin
                    doDisp = 1'b1;
                    dispRw = xfer_rw;
                end else if (evNow == EV_STOP) begin
                    stateNxt = ST_IDLE;
                end else if (rx_valid) begin
                    wdataNxt = rx_data;
                    reqNxt   = 1'b1;
                    loadReq  = 1'b1;
                    stateNxt = ST_WBUS;
                end
            end
            state[WBUS_B]: begin
                ovfSet = rx_valid & ~xfer_stop;
                if (done) begin
                    reqNxt  = 1'b0;
                    ptrNxt  = ptr + 1'b1;
                    tmoSet  = expire;
                    pendNxt = EV_NONE;
                    unique case (effEv)
                        EV_START: begin
                            doDisp = 1'b1;
                            dispRw = effRw;
                        end
                        EV_STOP: stateNxt = ST_IDLE;
                        default: stateNxt = ST_WDATA;
                    endcase
                end else if (evNow != EV_NONE) begin
                    pendNxt   = evNow;
                    pendRwNxt = xfer_rw;
                end
            end
            state[RFETCH_B]: begin
                unfSet = tx_req;
                if (done) begin
                    reqNxt   = 1'b0;
                    txBufNxt = ackIn ? regBus.reg_rdata : '1;
                    tmoSet   = expire;
                    pendNxt  = EV_NONE;
                    unique case (effEv)
                        EV_START: begin
                            doDisp = 1'b1;
                            dispRw = effRw;
                        end
                        EV_STOP: stateNxt = ST_IDLE;
                        default: stateNxt = ST_RHOLD;
                    endcase
                end else if (evNow != EV_NONE) begin
                    pendNxt   = evNow;
                    pendRwNxt = xfer_rw;
                end
            end
            state[RHOLD_B]: begin
                if (evNow == EV_START) begin
                    doDisp = 1'b1;
                    dispRw = xfer_rw;
                end else if (evNow == EV_STOP) begin
                    stateNxt = ST_IDLE;
                end else if (tx_req) begin
                    ptrNxt = ptr + 1'b1;
                    doDisp = 1'b1;
                    dispRw = 1'b1;
                end
            end
            default: stateNxt = ST_IDLE;
        endcase

        if (doDisp) begin
            stateNxt = dispRw ? ST_RFETCH : ST_PTR;
            if (dispRw) begin
                reqNxt  = 1'b1;
                loadReq = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            txBuf   <= '0;
            wdata   <= '0;
            reqQ    <= 1'b0;
            pendQ   <= EV_NONE;
            pendRwQ <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            err_tmo <= 1'b0;
        end else begin
            state   <= stateNxt;
            ptr     <= ptrNxt;
            txBuf   <= txBufNxt;
            wdata   <= wdataNxt;
            reqQ    <= reqNxt;
            pendQ   <= pendNxt;
            pendRwQ <= pendRwNxt;
            err_ovf <= ovfSet | (err_ovf & ~err_clr);
            err_unf <= unfSet | (err_unf & ~err_clr);
            err_tmo <= tmoSet | (err_tmo & ~err_clr);
        end
    end

    assign tx_valid         = state[RHOLD_B];
    assign tx_data          = txBuf;
    assign busy             = !state[IDLE_B];
    assign regBus.reg_req   = reqQ;
    assign regBus.reg_we    = reqQ & state[WBUS_B];
    assign regBus.reg_addr  = ptr;
    assign regBus.reg_wdata = wdata;

endmodule
